// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C slave receive path.
//   rx_state_t          : receive sequencer states
//   BITS_PER_BYTE       : serial bits per byte (excluding the ACK clock)
//   BIT_CNT_MAX         : bit counter value reached after a full byte
//   DEFAULT_SLAVE_ADDR  : 7-bit address used when no override is given
//   addr_match()        : true when a received address byte targets this
//                         slave with the write direction bit
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_CHK  = 3'd2,
        ACK_ADDR  = 3'd3,
        DATA      = 3'd4,
        DATA_CHK  = 3'd5,
        ACK_DATA  = 3'd6,
        NACK_WAIT = 3'd7
    } rx_state_t;

    localparam int         BITS_PER_BYTE      = 8;
    localparam logic [3:0] BIT_CNT_MAX        = 4'(BITS_PER_BYTE);
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1111000;
    localparam int         DEFAULT_MAX_BYTES  = 16;

    // Address byte is {addr[6:0], r_w}; only writes are accepted.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] slave_addr);
        return (addr_byte[7:1] == slave_addr) && (addr_byte[0] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_bit_cnt.sv
// ---------------------------------------------------------------------------
// i2c_bit_cnt
// Counts SCL rising edges within one byte and saturates at BITS_PER_BYTE.
// Ports:
//   clk    in   system clock
//   n_rst  in   synchronous active-low reset
//   clear  in   restart the count at 0 (wins over inc)
//   inc    in   count one SCL rising edge
//   done   out  byte complete: high in the cycle the last edge is counted
//                and while the count is held at BITS_PER_BYTE
// ---------------------------------------------------------------------------
module i2c_bit_cnt
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       last_edge;

    assign last_edge = inc && (cnt_q == (BIT_CNT_MAX - 4'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q < BIT_CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // done looks one edge ahead so the sequencer leaves the bit phase in the
    // same cycle the shift register takes its final bit; rx_data is then
    // complete in the following (check) cycle.
    assign done = !clear && ((cnt_q == BIT_CNT_MAX) || last_edge);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_rx_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_rx_ctrl
// Sequencer for the I2C slave receive path: enables the rx shift register,
// checks the address byte, drives ACK/NACK and pushes accepted data bytes
// into the RX FIFO.
// Ports:
//   clk                 in   system clock
//   n_rst               in   synchronous active-low reset
//   start_found         in   pulse, START / repeated START seen
//   stop_found          in   pulse, STOP seen
//   rising_edge_found   in   pulse, SCL rising edge
//   falling_edge_found  in   pulse, SCL falling edge
//   rx_data[7:0]        in   parallel value of the rx shift register
//   fifo_full           in   RX FIFO cannot take a byte
//   rx_enable           out  shift register may sample SDA
//   sda_ack             out  1 = pull SDA low for ACK
//   rx_push             out  pulse, write rx_data into the RX FIFO
//   busy                out  addressed transaction in progress
//   overflow            out  pulse, data byte NACKed (FIFO full / byte limit)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus free or not yet addressed, all outputs low
// ADDR      | shifting in the address byte
// ADDR_CHK  | one cycle, compare address byte and direction bit
// ACK_ADDR  | ACK window for the address byte
// DATA      | shifting in a data byte
// DATA_CHK  | one cycle, push the byte or refuse it
// ACK_DATA  | ACK window for a data byte
// NACK_WAIT | not ACKing anything until the next START or STOP
// ---------------------------------------------------------------------------
module i2c_rx_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         MAX_BYTES  = DEFAULT_MAX_BYTES
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic [7:0] rx_data,
    input  logic       fifo_full,
    output logic       rx_enable,
    output logic       sda_ack,
    output logic       rx_push,
    output logic       busy,
    output logic       overflow
);

    localparam int                    BYTE_CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = BYTE_CNT_W'(MAX_BYTES);

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_d;
    logic                  ack_q;
    logic                  ack_d;
    logic                  busy_q;
    logic                  busy_d;

    logic                  bit_clr;
    logic                  bit_inc;
    logic                  bit_done;
    logic                  byte_ok;
    logic                  in_shift;
    logic                  in_ack;

    assign in_shift = (state_q == ADDR) || (state_q == DATA);
    assign in_ack   = (state_q == ACK_ADDR) || (state_q == ACK_DATA);
    assign bit_inc  = rising_edge_found && in_shift;
    assign byte_ok  = !fifo_full && (byte_cnt_q < BYTE_CNT_MAX);

    i2c_bit_cnt u_bit_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (bit_clr),
        .inc   (bit_inc),
        .done  (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        bit_clr    = 1'b0;
        rx_push    = 1'b0;
        overflow   = 1'b0;

        if (start_found) begin
            state_d    = ADDR;
            byte_cnt_d = '0;
            ack_d      = 1'b0;
            busy_d     = 1'b0;
            bit_clr    = 1'b1;
        end else if (stop_found) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
            bit_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (bit_done) begin
                        state_d = ADDR_CHK;
                    end
                end
                ADDR_CHK: begin
                    if (addr_match(rx_data, SLAVE_ADDR)) begin
                        state_d = ACK_ADDR;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = NACK_WAIT;
                    end
                end
                // First falling edge closes bit 8 and opens the ACK bit;
                // the second closes the ACK clock and hands SDA back.
                ACK_ADDR, ACK_DATA: begin
                    if (falling_edge_found) begin
                        if (ack_q) begin
                            ack_d   = 1'b0;
                            state_d = DATA;
                            bit_clr = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        state_d = DATA_CHK;
                    end
                end
                DATA_CHK: begin
                    if (byte_ok) begin
                        rx_push    = 1'b1;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        state_d    = ACK_DATA;
                    end else begin
                        overflow = 1'b1;
                        state_d  = NACK_WAIT;
                    end
                end
                NACK_WAIT: begin
                end
                default: begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            endcase
        end
    end

    assign rx_enable = in_shift;
    assign sda_ack   = ack_q && in_ack;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_rx_ctrl
// Drives bit-level I2C event pulses into i2c_rx_ctrl, emulates the external
// rx shift register, and compares ACK behaviour, FIFO pushes, overflow pulses
// and busy against a transaction-level model of the slave.
// ---------------------------------------------------------------------------
module tb_i2c_rx_ctrl;

    localparam logic [6:0] MY_ADDR   = 7'h78;
    localparam int         MAX_BYTES = 16;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_found;
    logic       stop_found;
    logic       rising_edge_found;
    logic       falling_edge_found;
    logic [7:0] rx_data;
    logic       fifo_full;
    logic       rx_enable;
    logic       sda_ack;
    logic       rx_push;
    logic       busy;
    logic       overflow;

    i2c_rx_ctrl #(
        .SLAVE_ADDR (MY_ADDR),
        .MAX_BYTES  (MAX_BYTES)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .rx_data            (rx_data),
        .fifo_full          (fifo_full),
        .rx_enable          (rx_enable),
        .sda_ack            (sda_ack),
        .rx_push            (rx_push),
        .busy               (busy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO-side monitor: log every pushed byte and count overflow pulses.
    logic [7:0] push_log [0:4095];
    int         push_cnt = 0;
    int         ovf_seen = 0;

    always @(negedge clk) begin
        if (rx_push === 1'b1) begin
            push_log[push_cnt[11:0]] = rx_data;
            push_cnt = push_cnt + 1;
        end
        if (overflow === 1'b1) begin
            ovf_seen = ovf_seen + 1;
        end
    end

    // Per-transaction payload, written only by the main initial block.
    logic [7:0] txn_data [0:31];
    bit         txn_full [0:31];

    typedef struct {
        logic [7:0] addr;
        int         nbytes;
        int         full_idx;
        bit         end_stop;
        bit         exp_ack;
        int         exp_push;
        int         exp_ovf;
        bit         exp_busy;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_rise(input logic b);
        rising_edge_found = 1'b1;
        cyc();
        rising_edge_found = 1'b0;
        rx_data = {rx_data[6:0], b};
    endtask

    task automatic pulse_fall();
        falling_edge_found = 1'b1;
        cyc();
        falling_edge_found = 1'b0;
    endtask

    task automatic send_start();
        start_found = 1'b1;
        cyc();
        start_found = 1'b0;
    endtask

    task automatic send_stop();
        stop_found = 1'b1;
        cyc();
        stop_found = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int nbits, input bit exp_en);
        for (int i = 7; i > 7 - nbits; i--) begin
            idle(2);
            chk("rx_enable_bit", rx_enable, exp_en);
            pulse_rise(v[i]);
            idle(2);
            pulse_fall();
        end
    endtask

    task automatic ack_clock(input bit exp_ack, output bit seen);
        logic a1, a2, rel, e1;
        idle(1);
        a1 = sda_ack;
        e1 = rx_enable;
        pulse_rise(1'b0);
        a2 = sda_ack;
        pulse_fall();
        rel = sda_ack;
        chk("ack_after_bit8", a1, exp_ack);
        chk("ack_scl_high", a2, exp_ack);
        chk("ack_released", rel, 1'b0);
        chk("rx_enable_in_ack", e1, 1'b0);
        seen = a1 & a2;
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_rx_enable"}, rx_enable, 1'b0);
        chk({tag, "_sda_ack"}, sda_ack, 1'b0);
        chk({tag, "_rx_push"}, rx_push, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
    endtask

    // One transaction: model first, then drive, then compare.
    task automatic run_txn(input logic [7:0] addr, input int nbytes, input bit end_stop,
                           output bit addr_ack, output int n_push, output int n_ovf,
                           output bit busy_mid);
        bit         m_addr_ok;
        bit         m_nack;
        int         m_cnt;
        int         m_ovf;
        logic [7:0] m_push [$];
        bit         m_ack [0:31];
        bit         m_en [0:31];
        int         push_base;
        int         ovf_base;
        bit         ack;

        m_addr_ok = (addr[7:1] == MY_ADDR) && (addr[0] == 1'b0);
        m_nack    = !m_addr_ok;
        m_cnt     = 0;
        m_ovf     = 0;
        for (int i = 0; i < nbytes; i++) begin
            m_en[i] = !m_nack;
            if (m_nack) begin
                m_ack[i] = 1'b0;
            end else if (txn_full[i] || m_cnt >= MAX_BYTES) begin
                m_ack[i] = 1'b0;
                m_ovf++;
                m_nack = 1'b1;
            end else begin
                m_ack[i] = 1'b1;
                m_cnt++;
                m_push.push_back(txn_data[i]);
            end
        end

        push_base = push_cnt;
        ovf_base  = ovf_seen;
        send_start();
        chk("busy_after_start", busy, 1'b0);
        chk("rx_enable_after_start", rx_enable, 1'b1);
        send_bits(addr, 8, 1'b1);
        ack_clock(m_addr_ok, ack);
        addr_ack = ack;
        for (int i = 0; i < nbytes; i++) begin
            fifo_full = txn_full[i];
            send_bits(txn_data[i], 8, m_en[i]);
            ack_clock(m_ack[i], ack);
            fifo_full = 1'b0;
        end
        busy_mid = busy;
        chk("busy_in_txn", busy, m_addr_ok);
        if (end_stop) begin
            send_stop();
            chk("busy_after_stop", busy, 1'b0);
            chk("rx_enable_after_stop", rx_enable, 1'b0);
            chk("sda_ack_after_stop", sda_ack, 1'b0);
        end
        idle(1);
        n_push = push_cnt - push_base;
        n_ovf  = ovf_seen - ovf_base;
        chk("push_count", n_push, m_push.size());
        for (int i = 0; i < n_push && i < m_push.size(); i++) begin
            chk("push_data", push_log[(push_base + i) % 4096], m_push[i]);
        end
        chk("overflow_count", n_ovf, m_ovf);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         a_ack;
        bit         b_mid;
        int         np;
        int         no;
        int         base;
        int         r;
        logic [7:0] a;

        n_rst              = 1'b0;
        start_found        = 1'b0;
        stop_found         = 1'b0;
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        fifo_full          = 1'b0;
        rx_data            = 8'h00;

        vecs[0] = '{8'hF0,  1, -1, 1'b1, 1'b1,  1, 0, 1'b1};
        vecs[1] = '{8'hE0,  1, -1, 1'b1, 1'b0,  0, 0, 1'b0};
        vecs[2] = '{8'hF1,  1, -1, 1'b1, 1'b0,  0, 0, 1'b0};
        vecs[3] = '{8'hF0,  3,  1, 1'b1, 1'b1,  1, 1, 1'b1};
        vecs[4] = '{8'hF0, 17, -1, 1'b0, 1'b1, 16, 1, 1'b1};
        vecs[5] = '{8'hF0,  2, -1, 1'b1, 1'b1,  2, 0, 1'b1};
        vecs[6] = '{8'hF0,  0, -1, 1'b1, 1'b1,  0, 0, 1'b1};

        idle(2);
        check_all_low("reset");
        n_rst = 1'b1;
        idle(2);
        check_all_low("idle");

        // Table of directed transactions.
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 32; i++) begin
                txn_data[i] = (i == 0) ? 8'hA5 : 8'(8'h30 + i);
                txn_full[i] = (i == vecs[k].full_idx);
            end
            run_txn(vecs[k].addr, vecs[k].nbytes, vecs[k].end_stop, a_ack, np, no, b_mid);
            chk($sformatf("vec%0d_addr_ack", k), a_ack, vecs[k].exp_ack);
            chk($sformatf("vec%0d_pushes", k), np, vecs[k].exp_push);
            chk($sformatf("vec%0d_overflows", k), no, vecs[k].exp_ovf);
            chk($sformatf("vec%0d_busy", k), b_mid, vecs[k].exp_busy);
        end
        chk("vec0_push_value", push_log[0], 8'hA5);

        // Reset after 5 bits of the first data byte.
        send_start();
        send_bits(8'hF0, 8, 1'b1);
        ack_clock(1'b1, a_ack);
        base = push_cnt;
        send_bits(8'hA5, 5, 1'b1);
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
        check_all_low("mid_reset");
        send_bits(8'h00, 3, 1'b0);
        ack_clock(1'b0, a_ack);
        send_bits(8'h5A, 8, 1'b0);
        ack_clock(1'b0, a_ack);
        chk("mid_reset_no_push", push_cnt - base, 0);
        chk("mid_reset_busy", busy, 1'b0);

        // STOP inside the address ACK window.
        send_start();
        send_bits(8'hF0, 8, 1'b1);
        idle(1);
        chk("ack_before_stop", sda_ack, 1'b1);
        chk("busy_before_stop", busy, 1'b1);
        send_stop();
        chk("stop_in_ack_sda", sda_ack, 1'b0);
        chk("stop_in_ack_busy", busy, 1'b0);
        chk("stop_in_ack_rx_enable", rx_enable, 1'b0);
        send_bits(8'hFF, 2, 1'b0);

        // Repeated START inside a data ACK window.
        base = push_cnt;
        send_start();
        send_bits(8'hF0, 8, 1'b1);
        ack_clock(1'b1, a_ack);
        send_bits(8'h3C, 8, 1'b1);
        idle(1);
        chk("data_ack_before_start", sda_ack, 1'b1);
        send_start();
        chk("start_in_ack_sda", sda_ack, 1'b0);
        chk("start_in_ack_rx_enable", rx_enable, 1'b1);
        chk("start_in_ack_busy", busy, 1'b0);
        chk("start_in_ack_pushes", push_cnt - base, 1);
        chk("start_in_ack_value", push_log[base % 4096], 8'h3C);
        send_bits(8'hF0, 8, 1'b1);
        ack_clock(1'b1, a_ack);

        // START and STOP together: START wins.
        start_found = 1'b1;
        stop_found  = 1'b1;
        cyc();
        start_found = 1'b0;
        stop_found  = 1'b0;
        chk("start_beats_stop", rx_enable, 1'b1);
        send_bits(8'hE0, 8, 1'b1);
        ack_clock(1'b0, a_ack);
        send_stop();

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            if (r < 2)       a = 8'hF0;
            else if (r == 2) a = 8'hF1;
            else             a = 8'($urandom_range(0, 255));
            np = $urandom_range(0, 18);
            for (int i = 0; i < 32; i++) begin
                txn_data[i] = 8'($urandom_range(0, 255));
                txn_full[i] = ($urandom_range(0, 9) == 0);
            end
            run_txn(a, np, (t == 39) || ($urandom_range(0, 3) != 0), a_ack, np, no, b_mid);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
